// File: rtl/zports_ctrl_if.sv
`timescale 1ns/1ps
// Z80-side register bus between the zx-bus port decoder and zports_ctrl.
interface zports_ctrl_if;
    logic       wrena;
    logic       wrstb_n;
    logic [1:0] addr;
    logic [7:0] wrdata;
    logic [7:0] rddata;

    modport master (output wrena, wrstb_n, addr, wrdata, input rddata);
    modport slave  (input wrena, wrstb_n, addr, wrdata, output rddata);
endinterface

// File: rtl/zports_ctrl.sv
`timescale 1ns/1ps
// Control/status registers behind the zx-bus port decoder: ROM window, port routing, W5300/SL811
// reset sequencing and interrupt pending/mask; writes land 3 fclk after the strobe edge, reads are combinational.
module zports_ctrl #(
    parameter int RST_CYCLES   = 100,
    parameter int RECOV_CYCLES = 2000
) (
    input  logic         fclk,
    input  logic         rst,
    zports_ctrl_if.slave ports,
    output logic [1:0]   rommap_win,
    output logic         rommap_ena,
    output logic         w5300_ports,
    output logic         w5300_rst_n,
    output logic         sl811_rst_n,
    input  logic         w5300_int_n,
    input  logic         sl811_intrq,
    output logic         int_n
);
    typedef enum logic [1:0] {IDLE, ASSERT, RECOVER} seq_t;

    localparam logic [15:0] RST_LOAD   = 16'(RST_CYCLES - 1);
    localparam logic [15:0] RECOV_LOAD = 16'(RECOV_CYCLES - 1);

    logic [2:0]  stb_q;
    logic [1:0]  prime_q, prime_d;
    logic        armed_q, armed_d;
    logic [1:0]  wint_q, sint_q;
    logic [3:0]  cfg_q, cfg_d;
    logic [1:0]  mask_q, mask_d;
    logic [1:0]  pend_q, pend_d;
    logic        int_n_q;
    logic [1:0]  rst_n_q;
    seq_t        state_q [2];
    seq_t        state_d [2];
    logic [15:0] cnt_q [2];
    logic [15:0] cnt_d [2];

    logic       wr_hit;
    logic [1:0] trig, clr, busy, src_act;
    logic [1:0] wrdata_unused;

    assign wrdata_unused = ports.wrdata[7:6];

    // Edges are only accepted once the strobe has been seen high through the synchroniser,
    // so a strobe that is already low when reset releases never counts as a write.
    assign wr_hit  = armed_q & stb_q[2] & ~stb_q[1] & ports.wrena;
    assign src_act = {sint_q[1], ~wint_q[1]};

    always_comb begin
        prime_d = prime_q[1] ? prime_q : prime_q + 2'd1;
        armed_d = armed_q | (prime_q[1] & stb_q[1]);
        cfg_d   = cfg_q;
        mask_d  = mask_q;
        trig    = 2'b00;
        clr     = 2'b00;
        if (wr_hit) begin
            case (ports.addr)
                2'd1: cfg_d = ports.wrdata[3:0];
                2'd2: trig = ports.wrdata[1:0];
                2'd3: begin
                    clr    = ports.wrdata[1:0];
                    mask_d = ports.wrdata[5:4];
                end
                default: ;
            endcase
        end
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            busy[i]    = (state_q[i] != IDLE);
            case (state_q[i])
                IDLE: if (trig[i]) begin
                    state_d[i] = ASSERT;
                    cnt_d[i]   = RST_LOAD;
                end
                ASSERT: if (trig[i]) begin
                    cnt_d[i] = RST_LOAD;
                end else if (cnt_q[i] == 16'd0) begin
                    state_d[i] = RECOVER;
                    cnt_d[i]   = RECOV_LOAD;
                end else begin
                    cnt_d[i] = cnt_q[i] - 16'd1;
                end
                RECOVER: if (trig[i]) begin
                    state_d[i] = ASSERT;
                    cnt_d[i]   = RST_LOAD;
                end else if (cnt_q[i] == 16'd0) begin
                    state_d[i] = IDLE;
                end else begin
                    cnt_d[i] = cnt_q[i] - 16'd1;
                end
                default: state_d[i] = IDLE;
            endcase
            // A live source beats a clear; a chip under reset cannot hold an interrupt.
            if (busy[i])         pend_d[i] = 1'b0;
            else if (src_act[i]) pend_d[i] = 1'b1;
            else if (clr[i])     pend_d[i] = 1'b0;
            else                 pend_d[i] = pend_q[i];
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            stb_q   <= 3'b111;
            prime_q <= 2'd0;
            armed_q <= 1'b0;
            wint_q  <= 2'b11;
            sint_q  <= 2'b00;
            cfg_q   <= 4'h0;
            mask_q  <= 2'b00;
            pend_q  <= 2'b00;
            int_n_q <= 1'b1;
            rst_n_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ASSERT;
                cnt_q[i]   <= RST_LOAD;
            end
        end else begin
            stb_q   <= {stb_q[1:0], ports.wrstb_n};
            prime_q <= prime_d;
            armed_q <= armed_d;
            wint_q  <= {wint_q[0], w5300_int_n};
            sint_q  <= {sint_q[0], sl811_intrq};
            cfg_q   <= cfg_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            int_n_q <= ~|(pend_q & mask_q);
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                rst_n_q[i] <= (state_d[i] != ASSERT);
            end
        end
    end

    always_comb begin
        case (ports.addr)
            2'd1:    ports.rddata = {4'h0, cfg_q};
            2'd2:    ports.rddata = {6'b0, busy};
            2'd3:    ports.rddata = {2'b0, mask_q, 2'b0, pend_q};
            default: ports.rddata = 8'hFF;
        endcase
    end

    assign rommap_win  = cfg_q[1:0];
    assign rommap_ena  = cfg_q[2];
    assign w5300_ports = cfg_q[3];
    assign w5300_rst_n = rst_n_q[0];
    assign sl811_rst_n = rst_n_q[1];
    assign int_n       = int_n_q;
endmodule

// File: tb/tb_zports_ctrl.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for zports_ctrl against a timeline-based reference model.
module tb_zports_ctrl;
    localparam int RSTC = 4;
    localparam int RECC = 6;

    logic       fclk = 1'b0;
    logic       rst  = 1'b1;
    logic [1:0] rommap_win;
    logic       rommap_ena, w5300_ports, w5300_rst_n, sl811_rst_n, int_n;
    logic       w5300_int_n = 1'b1;
    logic       sl811_intrq = 1'b0;

    zports_ctrl_if bus();

    zports_ctrl #(.RST_CYCLES(RSTC), .RECOV_CYCLES(RECC)) dut (
        .fclk(fclk), .rst(rst), .ports(bus.slave),
        .rommap_win(rommap_win), .rommap_ena(rommap_ena), .w5300_ports(w5300_ports),
        .w5300_rst_n(w5300_rst_n), .sl811_rst_n(sl811_rst_n),
        .w5300_int_n(w5300_int_n), .sl811_intrq(sl811_intrq), .int_n(int_n)
    );

    always #5 fclk = ~fclk;

    int edge_n = 0;
    always @(posedge fclk) edge_n <= edge_n + 1;

    int vectors = 0;
    int miscompares = 0;

    // Model: each chip is low/busy in a window starting at the edge its latest trigger lands.
    int         e_prev [2] = '{-1000, -1000};
    int         e_cur  [2] = '{-1000, -1000};
    int         rs_from = -1000;
    int         rs_to   = -1000;
    logic [3:0] m_cfg  = 4'h0;
    logic [1:0] m_mask = 2'b00;
    logic [1:0] m_pend = 2'b00;
    bit         mon_on = 1'b0;

    function automatic int sel_e(int c, int n);
        return (n >= e_cur[c]) ? e_cur[c] : e_prev[c];
    endfunction

    function automatic bit in_rst(int n);
        return (n >= rs_from) && (n <= rs_to);
    endfunction

    function automatic bit m_rst_low(int c, int n);
        int e = sel_e(c, n);
        return in_rst(n) || (n >= e && n < e + RSTC);
    endfunction

    function automatic bit m_busy(int c, int n);
        int e = sel_e(c, n);
        return in_rst(n) || (n >= e && n < e + RSTC + RECC);
    endfunction

    function automatic logic [7:0] m_read(logic [1:0] a, int n);
        case (a)
            2'd1:    return {4'h0, m_cfg};
            2'd2:    return {6'b0, m_busy(1, n), m_busy(0, n)};
            2'd3:    return {2'b0, m_mask, 2'b0, m_pend};
            default: return 8'hFF;
        endcase
    endfunction

    typedef struct {
        bit         pins;
        logic [7:0] exp;
        string      name;
    } exp_t;
    exp_t exp_q[$];
    bit   chk_vld = 1'b0;

    always @(negedge fclk) begin
        logic [7:0] act;
        exp_t       e;
        if (chk_vld) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard: output presented with no expectation queued");
            end else begin
                e   = exp_q.pop_front();
                act = e.pins ? {1'b0, int_n, sl811_rst_n, w5300_rst_n, w5300_ports, rommap_ena, rommap_win}
                             : bus.rddata;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h (edge %0d)", e.name, act, e.exp, edge_n);
                end
            end
        end
        if (mon_on) begin
            vectors += 2;
            if (w5300_rst_n !== !m_rst_low(0, edge_n)) begin
                miscompares++;
                $display("FAIL w5300_rst_n: got %b expected %b (edge %0d)", w5300_rst_n, !m_rst_low(0, edge_n), edge_n);
            end
            if (sl811_rst_n !== !m_rst_low(1, edge_n)) begin
                miscompares++;
                $display("FAIL sl811_rst_n: got %b expected %b (edge %0d)", sl811_rst_n, !m_rst_low(1, edge_n), edge_n);
            end
        end
    end

    task automatic issue(input bit pins, input logic [7:0] exp, input string nm);
        exp_t e;
        e.pins = pins;
        e.exp  = exp;
        e.name = nm;
        exp_q.push_back(e);
        chk_vld = 1'b1;
        @(posedge fclk);
        #1 chk_vld = 1'b0;
    endtask

    task automatic expect_rd(input logic [1:0] a, input string nm);
        @(posedge fclk);
        #1 bus.addr = a;
        issue(1'b0, m_read(a, edge_n), nm);
    endtask

    task automatic expect_pins(input string nm);
        @(posedge fclk);
        #1 issue(1'b1, {1'b0, ~|(m_pend & m_mask), !m_rst_low(1, edge_n), !m_rst_low(0, edge_n), m_cfg}, nm);
    endtask

    task automatic model_write(input logic [1:0] a, input logic [7:0] d, input int p);
        case (a)
            2'd1: m_cfg = d[3:0];
            2'd2: for (int c = 0; c < 2; c++) if (d[c]) begin
                e_prev[c] = e_cur[c];
                e_cur[c]  = p + 3;
                m_pend[c] = 1'b0;
            end
            2'd3: begin
                m_mask = d[5:4];
                m_pend = m_pend & ~d[1:0];
            end
            default: ;
        endcase
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit en);
        @(posedge fclk);
        #1;
        bus.addr    = a;
        bus.wrdata  = d;
        bus.wrena   = en;
        bus.wrstb_n = 1'b0;
        if (en) model_write(a, d, edge_n);
        repeat (4) @(posedge fclk);
        #1 bus.wrstb_n = 1'b1;
        repeat (3) @(posedge fclk);
        #1 bus.wrena = 1'b0;
    endtask

    task automatic do_rst(input int k);
        @(posedge fclk);
        #1 rst = 1'b1;
        rs_from = edge_n + 1;
        rs_to   = edge_n + k;
        for (int c = 0; c < 2; c++) begin
            e_prev[c] = e_cur[c];
            e_cur[c]  = edge_n + k;
        end
        m_cfg  = 4'h0;
        m_mask = 2'b00;
        m_pend = 2'b00;
        repeat (k) @(posedge fclk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle();
        do begin
            @(posedge fclk);
            #1;
        end while (m_busy(0, edge_n) || m_busy(1, edge_n));
    endtask

    task automatic int_pulse(input int c, input int len);
        wait_idle();
        if (c == 0) w5300_int_n = 1'b0; else sl811_intrq = 1'b1;
        repeat (len) @(posedge fclk);
        #1;
        if (c == 0) w5300_int_n = 1'b1; else sl811_intrq = 1'b0;
        repeat (6) @(posedge fclk);
        m_pend[c] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        bus.wrena   = 1'b0;
        bus.wrstb_n = 1'b1;
        bus.addr    = 2'd0;
        bus.wrdata  = 8'h00;

        // Power-up: both chips pulsed, busy 03 then 00 after RST+RECOV cycles.
        do_rst(3);
        mon_on = 1'b1;
        expect_pins("reset_pins");
        for (int i = 0; i < 11; i++) expect_rd(2'd2, "busy_after_reset");
        expect_rd(2'd3, "int_reset");
        expect_rd(2'd1, "cfg_reset");

        wr(2'd1, 8'hFE, 1'b1);
        expect_rd(2'd1, "cfg_fe");
        expect_pins("cfg_fe_pins");
        expect_rd(2'd0, "addr0");

        wait_idle();
        wr(2'd2, 8'h01, 1'b1);
        wr(2'd2, 8'h01, 1'b1);
        expect_rd(2'd2, "retrigger_busy");
        wait_idle();

        wr(2'd3, 8'h10, 1'b1);
        int_pulse(0, 2);
        expect_rd(2'd3, "pend_set");
        expect_pins("int_asserted");
        wr(2'd3, 8'h01, 1'b1);
        expect_rd(2'd3, "pend_cleared");
        expect_pins("int_released");
        w5300_int_n = 1'b0;
        repeat (5) @(posedge fclk);
        m_pend[0] = 1'b1;
        wr(2'd3, 8'h11, 1'b1);
        m_pend[0] = 1'b1;
        expect_rd(2'd3, "pend_held");
        #1 w5300_int_n = 1'b1;
        repeat (5) @(posedge fclk);
        wr(2'd3, 8'h01, 1'b1);
        expect_rd(2'd3, "pend_after_release");

        wr(2'd1, 8'h05, 1'b0);
        @(posedge fclk);
        #1;
        bus.addr = 2'd1; bus.wrdata = 8'hAA; bus.wrena = 1'b1; bus.wrstb_n = 1'b0;
        #2 bus.wrstb_n = 1'b1;
        repeat (6) @(posedge fclk);
        #1 bus.wrena = 1'b0;
        expect_rd(2'd1, "cfg_unchanged");

        // Reset lands mid-ASSERT while the strobe is still low from the trigger write.
        wait_idle();
        bus.addr = 2'd2; bus.wrdata = 8'h03; bus.wrena = 1'b1; bus.wrstb_n = 1'b0;
        model_write(2'd2, 8'h03, edge_n);
        repeat (4) @(posedge fclk);
        do_rst(2);
        repeat (4) @(posedge fclk);
        #1 bus.wrstb_n = 1'b1;
        repeat (3) @(posedge fclk);
        #1 bus.wrena = 1'b0;
        expect_rd(2'd1, "cfg_after_midrst");
        expect_pins("pins_after_midrst");
        expect_rd(2'd2, "busy_after_midrst");

        for (int it = 0; it < 120; it++) begin
            op = $urandom_range(0, 6);
            case (op)
                0: wr(2'd1, 8'($urandom), 1'b1);
                1: wr(2'd3, 8'($urandom), 1'b1);
                2: wr(2'd2, 8'($urandom), 1'b1);
                3: int_pulse($urandom_range(0, 1), $urandom_range(2, 4));
                4: expect_rd(2'($urandom), "rand_read");
                5: wr(2'($urandom), 8'($urandom), 1'b0);
                default: expect_pins("rand_pins");
            endcase
            if (op != 4) expect_rd(2'($urandom), "rand_post_read");
        end

        repeat (4) @(posedge fclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
